// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencing controller, the ALU and the
// 7-segment display driver.
//   state_t     : controller FSM states
//   NUM_OPS_DEF : default number of ALU operations
//   OP_*        : op_sel encoding, shared with the ALU and the display
//   op_next     : op_sel increment with wrap modulo the operation count
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam int NUM_OPS_DEF = 8;
  localparam int OP_SEL_W    = 3;

  localparam logic [OP_SEL_W-1:0] OP_PASS_A = 3'd0;
  localparam logic [OP_SEL_W-1:0] OP_ADD    = 3'd1;
  localparam logic [OP_SEL_W-1:0] OP_SUB    = 3'd2;
  localparam logic [OP_SEL_W-1:0] OP_MUL    = 3'd3;
  localparam logic [OP_SEL_W-1:0] OP_AND    = 3'd4;
  localparam logic [OP_SEL_W-1:0] OP_OR     = 3'd5;
  localparam logic [OP_SEL_W-1:0] OP_XOR    = 3'd6;
  localparam logic [OP_SEL_W-1:0] OP_PASS_B = 3'd7;

  function automatic logic [OP_SEL_W-1:0] op_next(input logic [OP_SEL_W-1:0] op,
                                                 input int num_ops);
    if (int'(op) >= num_ops - 1) return '0;
    else return op + 3'd1;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_step_timer.sv
// Auto-step timer. Produces a one-cycle expire pulse every AUTO_DIV clocks
// while enabled and not held.
//   clk, reset : clock, asynchronous active-high reset
//   en         : enable; deasserting clears the count
//   hold       : freeze the count at its current value
//   expire     : high for the cycle in which the count is AUTO_DIV-1
// AUTO_DIV must be at least 2.
module step_timer #(
  parameter int AUTO_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic hold,
  output logic expire
);

  localparam int            CW   = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(AUTO_DIV - 1);

  logic [CW-1:0] cnt;

  assign expire = en && !hold && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!hold) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the switch-operand ALU / 7-segment datapath.
// Steps the ALU operation on a debounced button tick or an auto-step timer,
// latches the switch operands, waits out the ALU latency and captures the
// result, flagging when the displayed result is coherent with the inputs.
//   clk, reset   : clock, asynchronous active-high reset
//   btn_tick     : one-cycle debounced step pulse
//   auto_en      : enable the auto-step timer
//   hold         : freeze sequencing (steps are remembered, one deep)
//   sw_a, sw_b   : switch operands
//   alu_result   : ALU output, valid ALU_LAT cycles after its inputs settle
//   op_sel       : ALU operation select
//   alu_a, alu_b : latched operands to the ALU
//   result_q     : captured result for the display
//   result_valid : result_q matches op_sel / alu_a / alu_b
//   busy         : FSM outside IDLE
//   done         : one-cycle pulse on each capture
// NUM_OPS must not exceed 8 (3-bit op_sel); ALU_LAT must be at least 1.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NUM_OPS  = NUM_OPS_DEF,
  parameter int ALU_LAT  = 1,
  parameter int AUTO_DIV = 50_000_000,
  parameter int DW       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_tick,
  input  logic                auto_en,
  input  logic                hold,
  input  logic [DW-1:0]       sw_a,
  input  logic [DW-1:0]       sw_b,
  input  logic [2*DW-1:0]     alu_result,
  output logic [OP_SEL_W-1:0] op_sel,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [2*DW-1:0]     result_q,
  output logic                result_valid,
  output logic                busy,
  output logic                done
);

  localparam int             WCW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WCW-1:0] LAT_LAST = WCW'(ALU_LAT - 1);

  state_t         state, state_nx;
  logic           init, pend;
  logic [WCW-1:0] wcnt;
  logic           expire, step, operands_diff;
  logic           take_step, clr_init, enter_load;

  step_timer #(.AUTO_DIV(AUTO_DIV)) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .en     (auto_en),
    .hold   (hold),
    .expire (expire)
  );

  // A button tick coinciding with a timer expiry is a single step.
  assign step          = btn_tick | expire;
  assign operands_diff = ({sw_a, sw_b} != {alu_a, alu_b});
  assign busy          = (state != IDLE);
  assign enter_load    = (state == IDLE) && (state_nx == LOAD);

  always_comb begin
    state_nx  = state;
    take_step = 1'b0;
    clr_init  = 1'b0;
    case (state)
      IDLE: begin
        if (!hold) begin
          if (init) begin
            state_nx = LOAD;
            clr_init = 1'b1;
          end else if (step || pend) begin
            state_nx  = LOAD;
            take_step = 1'b1;
          end else if (operands_diff) begin
            state_nx = LOAD;
          end
        end
      end
      LOAD:    state_nx = WAIT;
      WAIT:    if (wcnt == LAT_LAST) state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init         <= 1'b1;
      pend         <= 1'b0;
      op_sel       <= '0;
      wcnt         <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      result_q     <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == CAPT);
      if (clr_init) init <= 1'b0;
      // One-deep step memory: a consumed step clears it, any other step
      // (while busy, held or during the init load) sets it.
      pend <= take_step ? 1'b0 : (pend | step);
      if (take_step) op_sel <= op_next(op_sel, NUM_OPS);
      // op_sel may change on this edge, so the old result stops being valid.
      if (enter_load) result_valid <= 1'b0;
      case (state)
        LOAD: begin
          alu_a        <= sw_a;
          alu_b        <= sw_b;
          result_valid <= 1'b0;
          wcnt         <= '0;
        end
        WAIT: wcnt <= wcnt + WCW'(1);
        CAPT: begin
          result_q     <= alu_result;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a registered 1-cycle ALU model.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int DW = 4, NUM_OPS = 8, ALU_LAT = 1, AUTO_DIV = 10;

  logic          clk = 1'b0, reset = 1'b1, btn_tick = 1'b0, auto_en = 1'b0, hold = 1'b0;
  logic [DW-1:0] sw_a = '0, sw_b = '0;
  logic [7:0]    alu_result = '0;
  logic [2:0]    op_sel;
  logic [DW-1:0] alu_a, alu_b;
  logic [7:0]    result_q;
  logic          result_valid, busy, done;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NUM_OPS(NUM_OPS), .ALU_LAT(ALU_LAT), .AUTO_DIV(AUTO_DIV), .DW(DW)) dut (
    .clk(clk), .reset(reset), .btn_tick(btn_tick), .auto_en(auto_en), .hold(hold),
    .sw_a(sw_a), .sw_b(sw_b), .alu_result(alu_result), .op_sel(op_sel),
    .alu_a(alu_a), .alu_b(alu_b), .result_q(result_q), .result_valid(result_valid),
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] x, y;
    x = {4'b0, a};
    y = {4'b0, b};
    case (op)
      OP_PASS_A: return x;
      OP_ADD:    return x + y;
      OP_SUB:    return x - y;
      OP_MUL:    return x * y;
      OP_AND:    return x & y;
      OP_OR:     return x | y;
      OP_XOR:    return x ^ y;
      default:   return y;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(op_sel, alu_a, alu_b);

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_btn();
    @(negedge clk); btn_tick = 1'b1;
    @(posedge clk); #1; btn_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (busy) begin bad++; $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, n); end
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_a = 4'd3; sw_b = 4'd5;
    tick(2);
    total++;
    if ({op_sel, alu_a, alu_b, result_q, result_valid, busy, done} !== 22'h0) begin
      bad++; $display("FAIL reset_outputs: got op=%0d a=%0d b=%0d r=%h v=%b busy=%b done=%b, need all 0",
                      op_sel, alu_a, alu_b, result_q, result_valid, busy, done);
    end
    @(negedge clk); reset = 1'b0;
    tick(1);
    total++; if (op_sel !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL init_accept: op=%0d busy=%b, need 0/1", op_sel, busy); end
    tick(1);
    total++; if (alu_a !== 4'd3 || alu_b !== 4'd5) begin bad++; $display("FAIL init_load: a=%0d b=%0d, need 3/5", alu_a, alu_b); end
    tick(1);
    total++; if (result_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL init_early: v=%b done=%b, need 0/0", result_valid, done); end
    tick(1);
    total++;
    if (result_q !== 8'h03 || result_valid !== 1'b1 || done !== 1'b1 || op_sel !== 3'd0) begin
      bad++; $display("FAIL init_capture: r=%h v=%b done=%b op=%0d, need 03/1/1/0", result_q, result_valid, done, op_sel);
    end
    tick(1);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL init_after: done=%b busy=%b, need 0/0", done, busy); end
  endtask

  task automatic test_button();
    pulse_btn();
    total++; if (op_sel !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL btn_op: op=%0d busy=%b, need 1/1", op_sel, busy); end
    tick(1);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL btn_valid_low: v=%b, need 0", result_valid); end
    tick(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL btn_done_early: done=%b, need 0", done); end
    tick(1);
    total++;
    if (done !== 1'b1 || result_valid !== 1'b1 || result_q !== 8'h08) begin
      bad++; $display("FAIL btn_capture: done=%b v=%b r=%h, need 1/1/08", done, result_valid, result_q);
    end
    tick(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL btn_done_width: done=%b, need 0", done); end
  endtask

  task automatic test_operand();
    sw_b = 4'd2;
    tick(1);
    total++; if (busy !== 1'b1 || op_sel !== 3'd1) begin bad++; $display("FAIL opnd_accept: busy=%b op=%0d, need 1/1", busy, op_sel); end
    tick(1);
    total++; if (alu_b !== 4'd2 || alu_a !== 4'd3) begin bad++; $display("FAIL opnd_load: a=%0d b=%0d, need 3/2", alu_a, alu_b); end
    tick(2);
    total++;
    if (done !== 1'b1 || result_valid !== 1'b1 || result_q !== 8'h05 || op_sel !== 3'd1) begin
      bad++; $display("FAIL opnd_capture: done=%b v=%b r=%h op=%0d, need 1/1/05/1", done, result_valid, result_q, op_sel);
    end
  endtask

  task automatic test_wrap_pend();
    for (int i = 0; i < 6; i++) begin pulse_btn(); wait_idle(); end
    total++;
    if (op_sel !== 3'd7 || result_q !== 8'h02 || result_valid !== 1'b1) begin
      bad++; $display("FAIL wrap_reach7: op=%0d r=%h v=%b, need 7/02/1", op_sel, result_q, result_valid);
    end
    pulse_btn();
    total++; if (op_sel !== 3'd0) begin bad++; $display("FAIL wrap_zero: op=%0d, need 0", op_sel); end
    pulse_btn();
    pulse_btn();
    total++; if (op_sel !== 3'd0) begin bad++; $display("FAIL wrap_busy_hold: op=%0d, need 0", op_sel); end
    tick(12);
    total++;
    if (op_sel !== 3'd1 || busy !== 1'b0 || result_valid !== 1'b1 || result_q !== 8'h05) begin
      bad++; $display("FAIL pend_one_deep: op=%0d busy=%b v=%b r=%h, need 1/0/1/05", op_sel, busy, result_valid, result_q);
    end
  endtask

  task automatic test_auto_hold();
    auto_en = 1'b1;
    tick(49);
    total++; if (op_sel !== 3'd5) begin bad++; $display("FAIL auto_before: op=%0d, need 5", op_sel); end
    tick(1);
    total++; if (op_sel !== 3'd6) begin bad++; $display("FAIL auto_step: op=%0d, need 6", op_sel); end
    hold = 1'b1;
    tick(5);
    btn_tick = 1'b1;
    tick(1);
    btn_tick = 1'b0;
    tick(19);
    total++;
    if (op_sel !== 3'd6 || busy !== 1'b0 || result_valid !== 1'b1) begin
      bad++; $display("FAIL hold_freeze: op=%0d busy=%b v=%b, need 6/0/1", op_sel, busy, result_valid);
    end
    hold = 1'b0;
    tick(1);
    total++; if (op_sel !== 3'd7 || busy !== 1'b1) begin bad++; $display("FAIL hold_pend_served: op=%0d busy=%b, need 7/1", op_sel, busy); end
    auto_en = 1'b0;
    tick(6);
    total++; if (op_sel !== 3'd7 || busy !== 1'b0) begin bad++; $display("FAIL auto_off: op=%0d busy=%b, need 7/0", op_sel, busy); end
    auto_en = 1'b1;
    tick(9);
    btn_tick = 1'b1;
    tick(1);
    btn_tick = 1'b0;
    total++; if (op_sel !== 3'd0) begin bad++; $display("FAIL coincide_step: op=%0d, need 0", op_sel); end
    tick(6);
    total++; if (op_sel !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL coincide_single: op=%0d busy=%b, need 0/0", op_sel, busy); end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_btn();
    tick(1);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({op_sel, alu_a, alu_b, result_q, result_valid, busy, done} !== 22'h0) begin
      bad++; $display("FAIL reset_async: op=%0d a=%0d b=%0d r=%h v=%b busy=%b done=%b, need all 0",
                      op_sel, alu_a, alu_b, result_q, result_valid, busy, done);
    end
    @(negedge clk); reset = 1'b0;
    tick(1);
    total++; if (op_sel !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL rst_init_accept: op=%0d busy=%b, need 0/1", op_sel, busy); end
    tick(3);
    total++;
    if (op_sel !== 3'd0 || result_q !== 8'h03 || result_valid !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL rst_init_capture: op=%0d r=%h v=%b done=%b, need 0/03/1/1", op_sel, result_q, result_valid, done);
    end
  endtask

  task automatic test_random();
    int m_op, m_a, m_b, m_res, m_left, m_tcnt;
    bit m_valid, m_done, m_init, m_pend, expm, stp, used;
    logic [21:0] got, exp_v;
    int nerr = 0;
    reset = 1'b1; auto_en = 1'b1; hold = 1'b0; btn_tick = 1'b0;
    tick(2);
    @(negedge clk); reset = 1'b0;
    m_op = 0; m_a = 0; m_b = 0; m_res = 0; m_left = 0; m_tcnt = 0;
    m_valid = 0; m_done = 0; m_init = 1; m_pend = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      btn_tick = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 14) == 0) sw_a = 4'($urandom);
      if ($urandom_range(0, 14) == 0) sw_b = 4'($urandom);
      @(posedge clk);
      // timer: expiry on the AUTO_DIV-th counted cycle
      expm = auto_en && !hold && (m_tcnt == AUTO_DIV - 1);
      if (!auto_en) m_tcnt = 0;
      else if (!hold) m_tcnt = (m_tcnt == AUTO_DIV - 1) ? 0 : m_tcnt + 1;
      stp = btn_tick || expm;
      used = 0;
      m_done = 0;
      // m_left counts edges remaining until capture once an operation starts
      if (m_left > 0) begin
        m_left--;
        if (m_left == ALU_LAT + 1) begin m_a = int'(sw_a); m_b = int'(sw_b); end
        if (m_left == 0) begin
          m_res = int'(alu_f(3'(m_op), 4'(m_a), 4'(m_b)));
          m_valid = 1; m_done = 1;
        end
      end else if (!hold) begin
        if (m_init) begin m_init = 0; m_left = ALU_LAT + 2; m_valid = 0; end
        else if (stp || m_pend) begin m_op = (m_op + 1) % NUM_OPS; used = 1; m_left = ALU_LAT + 2; m_valid = 0; end
        else if (int'(sw_a) != m_a || int'(sw_b) != m_b) begin m_left = ALU_LAT + 2; m_valid = 0; end
      end
      m_pend = used ? 1'b0 : (m_pend || stp);
      #1;
      got   = {op_sel, alu_a, alu_b, result_q, result_valid, busy, done};
      exp_v = {3'(m_op), 4'(m_a), 4'(m_b), 8'(m_res), m_valid, (m_left != 0), m_done};
      total++;
      if (got !== exp_v) begin
        bad++; nerr++;
        if (nerr <= 10) $display("FAIL rand_state cyc=%0d: got %h need %h", cyc, got, exp_v);
      end
      if (result_valid === 1'b1) begin
        total++;
        if (result_q !== alu_f(op_sel, alu_a, alu_b)) begin
          bad++; nerr++;
          if (nerr <= 10) $display("FAIL rand_coherent cyc=%0d: r=%h need %h", cyc, result_q, alu_f(op_sel, alu_a, alu_b));
        end
      end
      @(negedge clk);
    end
    btn_tick = 1'b0; hold = 1'b0; auto_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_button();
    test_operand();
    test_wrap_pend();
    test_auto_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
